// File: rtl/rng_address_gen_if.sv
// rng_address_gen_if
//   Bundles the request/response signals between the winner-policy FSM
//   (master) and the rng_address_gen responder (slave).
//   Ports carried:
//     en_rng              master -> slave  advance the LFSR
//     start_rngAddress    master -> slave  level request for an index
//     which               master -> slave  random value to reduce
//     betterNeighborCount master -> slave  number of valid table entries
//     rng_out             slave -> master  current LFSR state
//     rng_out_4bit        slave -> master  low nibble of the LFSR, zero-extended
//     rng_address         slave -> master  computed table index
//     done_rng_address    slave -> master  index valid (level)
//     busy                slave -> master  divider running
interface rng_address_gen_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  en_rng;
    logic                  start_rngAddress;
    logic [WORD_WIDTH-1:0] which;
    logic [WORD_WIDTH-1:0] betterNeighborCount;
    logic [WORD_WIDTH-1:0] rng_out;
    logic [WORD_WIDTH-1:0] rng_out_4bit;
    logic [WORD_WIDTH-1:0] rng_address;
    logic                  done_rng_address;
    logic                  busy;

    modport master (
        output en_rng, start_rngAddress, which, betterNeighborCount,
        input  rng_out, rng_out_4bit, rng_address, done_rng_address, busy
    );

    modport slave (
        input  en_rng, start_rngAddress, which, betterNeighborCount,
        output rng_out, rng_out_4bit, rng_address, done_rng_address, busy
    );
endinterface

// File: rtl/rng_address_gen.sv
// rng_address_gen
//   Responder for the winner-policy random requests. Owns a Galois LFSR
//   that supplies random numbers and a fixed-latency restoring divider that
//   reduces a random value modulo the (clamped) betterNeighbor count. The
//   returned index is later turned into the table address 0x668 + 2*index.
//   Ports:
//     clock  system clock, rising edge
//     nrst   synchronous active-high reset
//     bus    rng_address_gen_if slave modport (request/response signals)
module rng_address_gen #(
    parameter int                  WORD_WIDTH    = 16,
    parameter logic [WORD_WIDTH-1:0] LFSR_SEED   = 16'hACE1,
    parameter logic [WORD_WIDTH-1:0] LFSR_TAPS   = 16'hB400,
    parameter int                  MAX_NEIGHBORS = 18
) (
    input  logic             clock,
    input  logic             nrst,
    rng_address_gen_if.slave bus
);

    localparam int CNT_W = $clog2(WORD_WIDTH);

    // An all-zero seed would lock the LFSR at zero forever, so it is forced to 1.
    localparam logic [WORD_WIDTH-1:0] SEED_SAFE =
        (LFSR_SEED == '0) ? {{(WORD_WIDTH-1){1'b0}}, 1'b1} : LFSR_SEED;

    localparam logic [WORD_WIDTH-1:0] MAX_DIVISOR = WORD_WIDTH'(MAX_NEIGHBORS);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t                state_q, state_next;
    logic [WORD_WIDTH-1:0] lfsr_q;
    logic [WORD_WIDTH-1:0] dividend_q, dividend_next;
    logic [WORD_WIDTH-1:0] divisor_q, divisor_next;
    logic [WORD_WIDTH-1:0] remainder_q, remainder_next;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_next;
    logic [WORD_WIDTH-1:0] addr_q, addr_next;
    logic                  done_q, done_next;
    logic                  busy_q, busy_next;

    logic [WORD_WIDTH-1:0] clamped_count;
    logic [WORD_WIDTH:0]   trial;
    logic [WORD_WIDTH-1:0] trial_low;
    logic                  trial_ge;
    logic [WORD_WIDTH-1:0] step_rem;

    // The LFSR advances only on en_rng and is completely independent of the
    // address FSM, so a random request and an index request can overlap.
    always_ff @(posedge clock) begin
        if (nrst) begin
            lfsr_q <= SEED_SAFE;
        end else if (bus.en_rng) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    // One restoring-division step. The trial value is one bit wider than the
    // word so the shifted remainder can never wrap before the compare. When
    // the trial is >= divisor the true difference is below the divisor, so
    // subtracting on the low word alone gives the exact result.
    always_comb begin
        clamped_count = (bus.betterNeighborCount > MAX_DIVISOR) ? MAX_DIVISOR
                                                                 : bus.betterNeighborCount;
        trial     = {remainder_q, dividend_q[WORD_WIDTH-1]};
        trial_low = trial[WORD_WIDTH-1:0];
        trial_ge  = (trial >= {1'b0, divisor_q});
        step_rem  = trial_ge ? (trial_low - divisor_q) : trial_low;
    end

    // Next-state and datapath decisions. Operands are latched on the accepting
    // edge so later changes on which/count do not disturb a running division.
    // done and busy are derived from the next state so they are registered
    // together with it and never glitch from inputs.
    always_comb begin
        state_next     = state_q;
        dividend_next  = dividend_q;
        divisor_next   = divisor_q;
        remainder_next = remainder_q;
        bit_cnt_next   = bit_cnt_q;
        addr_next      = addr_q;

        case (state_q)
            IDLE: begin
                if (bus.start_rngAddress) begin
                    dividend_next = bus.which;
                    divisor_next  = clamped_count;
                    if (clamped_count == '0) begin
                        addr_next  = '0;
                        state_next = DONE;
                    end else begin
                        remainder_next = '0;
                        bit_cnt_next   = CNT_W'(WORD_WIDTH - 1);
                        state_next     = DIV;
                    end
                end
            end
            DIV: begin
                remainder_next = step_rem;
                dividend_next  = dividend_q << 1;
                bit_cnt_next   = bit_cnt_q - 1'b1;
                if (bit_cnt_q == '0) begin
                    addr_next  = step_rem;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!bus.start_rngAddress) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        done_next = (state_next == DONE);
        busy_next = (state_next == DIV);
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clock) begin
        if (nrst) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            remainder_q <= '0;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_next;
            dividend_q  <= dividend_next;
            divisor_q   <= divisor_next;
            remainder_q <= remainder_next;
            bit_cnt_q   <= bit_cnt_next;
            addr_q      <= addr_next;
            done_q      <= done_next;
            busy_q      <= busy_next;
        end
    end

    assign bus.rng_out          = lfsr_q;
    assign bus.rng_out_4bit     = {{(WORD_WIDTH-4){1'b0}}, lfsr_q[3:0]};
    assign bus.rng_address      = addr_q;
    assign bus.done_rng_address = done_q;
    assign bus.busy             = busy_q;

endmodule

// File: tb/tb_rng_address_gen.sv
// tb_rng_address_gen
//   Drives rng_address_gen with directed and random requests and compares
//   every output on every cycle against a transaction-level model that uses
//   plain modulo arithmetic and a cycle countdown.
module tb_rng_address_gen;

    localparam int          W     = 16;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [15:0] TAPS  = 16'hB400;
    localparam int          MAXN  = 18;

    logic clock = 1'b0;
    logic nrst  = 1'b1;

    always #5 clock = ~clock;

    rng_address_gen_if #(.WORD_WIDTH(W)) ifc ();

    rng_address_gen #(
        .WORD_WIDTH   (W),
        .LFSR_SEED    (SEED),
        .LFSR_TAPS    (TAPS),
        .MAX_NEIGHBORS(MAXN)
    ) dut (
        .clock(clock),
        .nrst (nrst),
        .bus  (ifc)
    );

    int checks   = 0;
    int errors   = 0;
    bit check_en = 1'b0;

    // Reference model state: phase 0 = waiting, 1 = computing, 2 = result held.
    logic [15:0] m_lfsr;
    logic [15:0] m_addr;
    logic [15:0] m_pending;
    logic        m_done;
    logic        m_busy;
    int          m_phase;
    int          m_left;

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic start,
                                 input logic [15:0] w, input logic [15:0] c);
        ifc.en_rng              = en;
        ifc.start_rngAddress    = start;
        ifc.which               = w;
        ifc.betterNeighborCount = c;
    endtask

    // Model: the result is the plain remainder which % min(count, MAXN),
    // delivered 16 edges after acceptance (or at once for a zero divisor).
    always @(posedge clock) begin
        if (nrst) begin
            m_lfsr  = SEED;
            m_addr  = 16'h0000;
            m_done  = 1'b0;
            m_busy  = 1'b0;
            m_phase = 0;
            m_left  = 0;
        end else begin
            int d;
            if (ifc.en_rng) m_lfsr = lfsrNext(m_lfsr);
            case (m_phase)
                0: begin
                    if (ifc.start_rngAddress) begin
                        d = (int'(ifc.betterNeighborCount) > MAXN) ? MAXN
                                                                  : int'(ifc.betterNeighborCount);
                        if (d == 0) begin
                            m_addr  = 16'h0000;
                            m_done  = 1'b1;
                            m_phase = 2;
                        end else begin
                            m_pending = 16'(int'(ifc.which) % d);
                            m_left    = 16;
                            m_busy    = 1'b1;
                            m_phase   = 1;
                        end
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_addr  = m_pending;
                        m_busy  = 1'b0;
                        m_done  = 1'b1;
                        m_phase = 2;
                    end
                end
                default: begin
                    if (!ifc.start_rngAddress) begin
                        m_done  = 1'b0;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("rng_out",      ifc.rng_out,      m_lfsr);
            checkOutput("rng_out_4bit", ifc.rng_out_4bit, {12'h000, m_lfsr[3:0]});
            checkOutput("rng_address",  ifc.rng_address,  m_addr);
            checkOutput("done",         16'(ifc.done_rng_address), 16'(m_done));
            checkOutput("busy",         16'(ifc.busy),    16'(m_busy));
        end
    end

    // Issues one request and checks the literal result. exp_edges counts the
    // negedge on which done first appears, the acceptance edge being the first.
    task automatic runRequest(input string tag, input logic [15:0] w,
                              input logic [15:0] c, input logic [15:0] exp_addr,
                              input int exp_edges, input int exp_busy,
                              input int hold, input bit rand_en);
        int  edges;
        int  busy_cycles;
        bit  seen;
        edges       = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        applyStimulus(1'b0, 1'b1, w, c);
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clock);
            if (ifc.busy) busy_cycles++;
            if (ifc.done_rng_address) begin
                seen  = 1'b1;
                edges = k;
            end
            if (rand_en) begin
                ifc.en_rng              = 1'($urandom_range(0, 1));
                ifc.which               = 16'($urandom);
                ifc.betterNeighborCount = 16'($urandom_range(0, 40));
            end
        end
        if (!seen) begin
            checkOutput({tag, " done timeout"}, 16'h0000, 16'h0001);
        end else begin
            checkOutput({tag, " edges"}, 16'(edges), 16'(exp_edges));
            checkOutput({tag, " busy cycles"}, 16'(busy_cycles), 16'(exp_busy));
            checkOutput({tag, " addr"}, ifc.rng_address, exp_addr);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            checkOutput({tag, " held done"}, 16'(ifc.done_rng_address), 16'h0001);
            checkOutput({tag, " held addr"}, ifc.rng_address, exp_addr);
        end
        ifc.start_rngAddress = 1'b0;
        ifc.en_rng           = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clock);
            if (!ifc.done_rng_address) seen = 1'b1;
        end
        checkOutput({tag, " done release"}, 16'(seen), 16'h0001);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hi_left;
        int lo_left;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        nrst = 1'b1;
        repeat (2) @(negedge clock);
        nrst     = 1'b0;
        check_en = 1'b1;

        // LFSR sequence pinned to hand-computed values.
        checkOutput("lfsr seed",   ifc.rng_out, 16'hACE1);
        checkOutput("lfsr4 seed",  ifc.rng_out_4bit, 16'h0001);
        ifc.en_rng = 1'b1;
        @(negedge clock);
        checkOutput("lfsr step1",  ifc.rng_out, 16'hE270);
        checkOutput("lfsr4 step1", ifc.rng_out_4bit, 16'h0000);
        @(negedge clock);
        ifc.en_rng = 1'b0;
        checkOutput("lfsr step2",  ifc.rng_out, 16'h7138);
        checkOutput("lfsr4 step2", ifc.rng_out_4bit, 16'h0008);
        repeat (3) @(negedge clock);
        checkOutput("lfsr hold",   ifc.rng_out, 16'h7138);

        // Directed divisions with literal results.
        runRequest("13 mod 5",    16'd13,   16'd5,  16'd3,  17, 16, 0, 1'b0);
        runRequest("255 mod 18",  16'h00FF, 16'd18, 16'd3,  17, 16, 0, 1'b1);
        runRequest("15 mod 40c",  16'd15,   16'd40, 16'd15, 17, 16, 0, 1'b1);
        runRequest("count zero",  16'd9,    16'd0,  16'd0,  1,  0,  0, 1'b0);
        runRequest("0 mod 7",     16'd0,    16'd7,  16'd0,  17, 16, 5, 1'b1);
        runRequest("7 mod 4",     16'd7,    16'd4,  16'd3,  17, 16, 0, 1'b1);

        // Reset in the middle of a division.
        applyStimulus(1'b1, 1'b1, 16'd13, 16'd5);
        repeat (8) @(negedge clock);
        nrst = 1'b1;
        @(negedge clock);
        checkOutput("midreset done",  16'(ifc.done_rng_address), 16'h0000);
        checkOutput("midreset busy",  16'(ifc.busy), 16'h0000);
        checkOutput("midreset addr",  ifc.rng_address, 16'h0000);
        checkOutput("midreset lfsr",  ifc.rng_out, 16'hACE1);
        nrst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clock);
        runRequest("100 mod 9",   16'd100,  16'd9,  16'd1,  17, 16, 0, 1'b0);

        // Random traffic: random en_rng, start bursts of random length that
        // may drop mid-division, operands churning while start is high.
        hi_left = 0;
        lo_left = 1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clock);
            ifc.en_rng = 1'($urandom_range(0, 1));
            if (lo_left > 0) begin
                ifc.start_rngAddress = 1'b0;
                lo_left--;
                if (lo_left == 0) hi_left = $urandom_range(1, 25);
            end else begin
                ifc.start_rngAddress = 1'b1;
                hi_left--;
                if (hi_left == 0) lo_left = $urandom_range(1, 3);
            end
            ifc.which               = 16'($urandom);
            ifc.betterNeighborCount = ($urandom_range(0, 7) == 0) ? 16'h0000
                                                                   : 16'($urandom_range(1, 40));
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (20) @(negedge clock);
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_address_gen.md
Name: rng_address_gen

Overview:
- Responder for winner-policy random requests: serves the `en_rng` random-number request and the `start_rngAddress`/`done_rng_address` neighbor-index handshake.
- Owns a 16-bit Galois LFSR that supplies `rng_out` and `rng_out_4bit`.
- Owns a fixed-latency restoring divider that returns `which mod betterNeighborCount` as the betterNeighbor table index.
- Sits beside the policy FSM in each node top; the index it returns is later used as address 0x668 + 2*index.

Parameters:
- WORD_WIDTH, 16, data and port word width.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.
- LFSR_TAPS, 16'hB400, Galois feedback mask.
- MAX_NEIGHBORS, 18, number of entries in the betterNeighbor table (0x668..0x68A); divisor clamp.

Ports:
- clock  in  1  system clock, rising edge.
- nrst  in  1  reset; synchronous, active-high: a 1 sampled at a clock edge resets the block.
- en_rng  in  1  advance request for the random number generator.
- start_rngAddress  in  1  level request to compute an index.
- which  in  16  random value to reduce.
- betterNeighborCount  in  16  number of valid table entries.
- rng_out  out  16  current LFSR state.
- rng_out_4bit  out  16  {12'b0, LFSR[3:0]}.
- rng_address  out  16  computed index, held stable until the next computation.
- done_rng_address  out  1  level; index valid.
- busy  out  1  high while the divider is computing.

Behaviour:
- Reset (nrst=1 at an edge):
  - lfsr = LFSR_SEED (0 replaced by 1).
  - rng_address = 0, done_rng_address = 0, busy = 0, FSM = IDLE.
  - Reset overrides any in-flight computation or request.
- LFSR:
  - At each edge with en_rng=1: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
  - Otherwise the LFSR holds.
  - Outputs always show the current state. A consumer sampling at the same edge that advances the LFSR gets the pre-advance value.
  - The LFSR never reaches 0.
  - The LFSR runs independently of the address FSM; simultaneous en_rng and start are both serviced.
- Address FSM, states IDLE, DIV, DONE:
  - IDLE: when start_rngAddress=1, latch which into dividend.
    - Divisor = min(betterNeighborCount, MAX_NEIGHBORS).
    - If the divisor is 0: rng_address <= 0 and go to DONE.
    - Otherwise: remainder <= 0, bit counter <= 15, busy <= 1, go to DIV.
  - DIV: one restoring step per cycle, MSB first.
    - r = {remainder[14:0], dividend[15]}; shift the dividend left.
    - If r >= divisor, remainder <= r - divisor; else remainder <= r.
    - Run for exactly 16 cycles. On the 16th step, write the final remainder to rng_address, busy <= 0, go to DONE.
    - Intermediate remainders use a 17-bit compare width; no overflow.
  - DONE: done_rng_address = 1.
    - Stay in DONE while start_rngAddress=1.
    - When start_rngAddress=0: done <= 0, go to IDLE.
    - A new request needs start low for at least 1 cycle, so there is no retrigger from a held start.
- Latency, with E0 = the edge that samples start high in IDLE:
  - Normal case: done is visible after E16 (16 cycles).
  - Divisor 0: done is visible after E0 (1 cycle).
- Changes on `which` or `betterNeighborCount` after E0 are ignored; operands are latched.
- Guarantee: rng_address < divisor whenever divisor > 0.
- Dropping start_rngAddress while in DIV:
  - The computation completes and rng_address is updated.
  - DONE exits on the next cycle because start is already low.
  - done pulses high for 1 cycle.
- No outputs change combinationally from inputs; all outputs are registered.

Test Plan:
- Reset, then en_rng held 2 cycles -> rng_out reads 0xACE1, 0xE270, 0x7138; rng_out_4bit reads 1, 0, 8. With en_rng=0 the value holds 0x7138.
- which=13, betterNeighborCount=5, start held until done -> done_rng_address rises 16 cycles after start sampled, rng_address=3, busy high for those 16 cycles.
- which=0x00FF, count=18 -> rng_address=3. which=15, count=40 (clamped to 18) -> rng_address=15.
- count=0, which=9 -> rng_address=0, done after 1 cycle. which=0, count=7 -> rng_address=0 after 16 cycles.
- Start held 5 cycles past done -> done stays 1, no recompute. Start low 1 cycle then high with which=7, count=4 -> new result 3. en_rng toggled during DIV -> LFSR advances correctly and the division result is unaffected.
- nrst=1 asserted mid-DIV (cycle 8) -> next cycle done=0, busy=0, rng_address=0, rng_out=0xACE1. A subsequent request completes normally.
